// File: rtl/proj_residual_writer_pkg.sv
// Shared parameters, destination names and FSM encoding for the residual receive path.
package proj_residual_writer_pkg;

   localparam int NDEST  = 12;
   localparam int DATA_W = 54;
   localparam int ADDR_W = 6;
   localparam int PAGE_W = 3;
   localparam int DEST_W = 4;
   localparam int WA_W   = PAGE_W + ADDR_W;

   localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

   typedef enum logic [DEST_W-1:0] {
      L1L2_1 = 4'd0, L1L2_2 = 4'd1, L1L2_3 = 4'd2,  L1L2_4 = 4'd3,
      L3L4_1 = 4'd4, L3L4_2 = 4'd5, L3L4_3 = 4'd6,  L3L4_4 = 4'd7,
      L5L6_1 = 4'd8, L5L6_2 = 4'd9, L5L6_3 = 4'd10, L5L6_4 = 4'd11
   } dest_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/proj_residual_writer_counter.sv
// Per-destination saturating item counter; clear with a simultaneous increment yields 1.
module residual_wr_counter
   import proj_residual_writer_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              inc,
   output logic              full,
   output logic [ADDR_W-1:0] count,
   output logic [ADDR_W-1:0] count_next
);

   assign full = (count == CNT_MAX);

   // Next count: clear wins, increment holds at the all-ones ceiling
   always_comb begin
      count_next = count;
      if (clear) begin
         count_next = inc ? ADDR_W'(1) : ADDR_W'(0);
      end else if (inc && !full) begin
         count_next = count + ADDR_W'(1);
      end else begin
         count_next = count;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= {ADDR_W{1'b0}};
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/proj_residual_writer.sv
// Writes returned residual words into per-destination paged memories and publishes
// per-destination item counts at the end of every BX.
module proj_residual_writer
   import proj_residual_writer_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [PAGE_W-1:0]       BX,
   input  logic                    in_valid,
   input  logic [DEST_W-1:0]       in_dest,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_last,
   output logic [NDEST-1:0]        wr_en,
   output logic [NDEST*WA_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]       wr_data,
   output logic [NDEST*ADDR_W-1:0] nitems,
   output logic                    done,
   output logic                    overflow,
   output logic                    bad_dest
);

   state_e                    state_r;
   logic [PAGE_W-1:0]         page_r;
   logic [PAGE_W-1:0]         page_s;
   logic                      valid_s;
   logic                      ovf_s;
   logic                      bad_s;
   logic [NDEST-1:0]          dec_s;
   logic [NDEST-1:0]          full_s;
   logic [NDEST-1:0]          wr_s;
   logic [NDEST*ADDR_W-1:0]   cnt_s;
   logic [NDEST*ADDR_W-1:0]   cnt_nxt_s;
   logic [NDEST*WA_W-1:0]     widx_s;

   // Acceptance, destination decode and drop classification
   always_comb begin
      valid_s = in_valid && (start || (state_r == ST_RUN));
      page_s  = start ? BX : page_r;
      dec_s   = {NDEST{1'b0}};
      wr_s    = {NDEST{1'b0}};
      widx_s  = {(NDEST*WA_W){1'b0}};
      for (int d = 0; d < NDEST; d++) begin
         dec_s[d] = (in_dest == DEST_W'(d));
         // a starting BX has freshly cleared counters, so nothing is full yet
         wr_s[d]  = valid_s && dec_s[d] && (start || !full_s[d]);
         widx_s[d*WA_W +: WA_W] = {page_s, start ? {ADDR_W{1'b0}} : cnt_s[d*ADDR_W +: ADDR_W]};
      end
      ovf_s = valid_s && !start && |(dec_s & full_s);
      bad_s = valid_s && !(|dec_s);
   end

   for (genvar g = 0; g < NDEST; g++) begin : g_cnt
      residual_wr_counter u_cnt (
         .clk        (clk),
         .reset_n    (reset_n),
         .clear      (start),
         .inc        (wr_s[g]),
         .full       (full_s[g]),
         .count      (cnt_s[g*ADDR_W +: ADDR_W]),
         .count_next (cnt_nxt_s[g*ADDR_W +: ADDR_W])
      );
   end

   // BX sequencing FSM and count publication
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         done    <= 1'b0;
         nitems  <= {(NDEST*ADDR_W){1'b0}};
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               state_r <= start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
               if (start) begin
                  done    <= 1'b1;
                  nitems  <= cnt_s;
                  state_r <= ST_RUN;
               end else if (in_last) begin
                  // publish including the word accepted alongside in_last
                  done    <= 1'b1;
                  nitems  <= cnt_nxt_s;
                  state_r <= ST_FLUSH;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_FLUSH: begin
               state_r <= start ? ST_RUN : ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Write port, page latch and per-BX sticky flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en    <= {NDEST{1'b0}};
         wr_addr  <= {(NDEST*WA_W){1'b0}};
         wr_data  <= {DATA_W{1'b0}};
         page_r   <= {PAGE_W{1'b0}};
         overflow <= 1'b0;
         bad_dest <= 1'b0;
      end else begin
         wr_en  <= wr_s;
         page_r <= page_s;
         if (|wr_s) begin
            wr_data <= in_data;
         end else begin
            wr_data <= wr_data;
         end
         for (int d = 0; d < NDEST; d++) begin
            if (wr_s[d]) begin
               wr_addr[d*WA_W +: WA_W] <= widx_s[d*WA_W +: WA_W];
            end else begin
               wr_addr[d*WA_W +: WA_W] <= wr_addr[d*WA_W +: WA_W];
            end
         end
         overflow <= (start ? 1'b0 : overflow) | ovf_s;
         bad_dest <= (start ? 1'b0 : bad_dest) | bad_s;
      end
   end

endmodule
